// File: rtl/axil_rd_streamer_if.sv
// AXI-Lite read channel plus AXI-Stream output bundled for the read streamer.
interface axil_rd_streamer_if #(
    parameter int DW           = 32,
    parameter int G_ADDR_WIDTH = 10
);
    // AXI-Lite read address / data channels
    logic                    m_axil_arvalid;
    logic                    m_axil_arready;
    logic [G_ADDR_WIDTH-1:0] m_axil_araddr;
    logic                    m_axil_rvalid;
    logic                    m_axil_rready;
    logic [DW-1:0]           m_axil_rdata;
    logic [1:0]              m_axil_rresp;
    // AXI-Stream output
    logic                    m_tvalid;
    logic                    m_tready;
    logic [DW-1:0]           m_tdata;
    logic                    m_tlast;

    // Streamer side: initiates reads, sources the stream
    modport master (
        output m_axil_arvalid, m_axil_araddr, m_axil_rready,
        output m_tvalid, m_tdata, m_tlast,
        input  m_axil_arready, m_axil_rvalid, m_axil_rdata, m_axil_rresp,
        input  m_tready
    );

    // Memory-slave / stream-sink side
    modport slave (
        input  m_axil_arvalid, m_axil_araddr, m_axil_rready,
        input  m_tvalid, m_tdata, m_tlast,
        output m_axil_arready, m_axil_rvalid, m_axil_rdata, m_axil_rresp,
        output m_tready
    );
endinterface

// File: rtl/axil_rd_streamer.sv
// AXI-Lite read initiator: sweeps base + k*stride for len words, one read
// outstanding, and forwards each returned word as one AXI-Stream beat.
module axil_rd_streamer #(
    parameter int DW           = 32,
    parameter int G_ADDR_WIDTH = 10,
    parameter int G_LEN_WIDTH  = G_ADDR_WIDTH + 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [G_ADDR_WIDTH-1:0] i_base,
    input  logic [G_ADDR_WIDTH-1:0] i_stride,
    input  logic [G_LEN_WIDTH-1:0]  i_len,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    axil_rd_streamer_if.master      bus
);

    typedef enum logic [1:0] {StIdle, StAr, StR, StOut} state_e;

    state_e                  state_q, state_d;
    logic [G_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [G_ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [G_LEN_WIDTH-1:0]  len_q, len_d;
    logic [G_LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [DW-1:0]           tdata_q, tdata_d;
    logic                    tlast_q, tlast_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;

    // Next-state and datapath updates for the sweep FSM
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        len_d    = len_q;
        idx_d    = idx_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        err_d    = err_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    addr_d   = i_base;
                    stride_d = i_stride;
                    len_d    = i_len;
                    idx_d    = '0;
                    err_d    = 1'b0;
                    tlast_d  = 1'b0;
                    // Zero-length sweep completes without touching the bus
                    if (i_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StAr;
                    end
                end
            end
            StAr: begin
                if (bus.m_axil_arready) begin
                    state_d = StR;
                end
            end
            StR: begin
                if (bus.m_axil_rvalid) begin
                    // Data is forwarded even when the response is an error
                    tdata_d = bus.m_axil_rdata;
                    err_d   = err_q | (bus.m_axil_rresp != 2'b00);
                    tlast_d = (idx_q == len_q - G_LEN_WIDTH'(1));
                    state_d = StOut;
                end
            end
            StOut: begin
                if (bus.m_tready) begin
                    if (tlast_q) begin
                        tlast_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        // Address wraps silently at 2^G_ADDR_WIDTH
                        addr_d  = addr_q + stride_q;
                        idx_d   = idx_q + G_LEN_WIDTH'(1);
                        state_d = StAr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            stride_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    // Handshake outputs decode directly from the registered state
    always_comb begin
        bus.m_axil_arvalid = (state_q == StAr);
        bus.m_axil_araddr  = addr_q;
        bus.m_axil_rready  = (state_q == StR);
        bus.m_tvalid       = (state_q == StOut);
        bus.m_tdata        = tdata_q;
        bus.m_tlast        = tlast_q;
        o_busy             = (state_q != StIdle);
        o_done             = done_q;
        o_err              = err_q;
    end

endmodule

// File: tb/tb_axil_rd_streamer.sv
// Self-checking bench for axil_rd_streamer: table of sweeps plus hand-written
// sequences for error timing, start-while-busy and mid-sweep reset.
module tb_axil_rd_streamer;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int LW = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    axil_rd_streamer_if #(.DW(DW), .G_ADDR_WIDTH(AW)) bus ();

    axil_rd_streamer #(.DW(DW), .G_ADDR_WIDTH(AW), .G_LEN_WIDTH(LW)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_base   (base),
        .i_stride (stride),
        .i_len    (len),
        .o_busy   (busy),
        .o_done   (done),
        .o_err    (err),
        .bus      (bus)
    );

    // Slave / sink behaviour knobs (written only by the test process)
    int ar_dly   = 0;   // cycles arvalid waits before arready
    int err_addr = -1;  // address answered with rresp=2
    int tr_mode  = 0;   // 0 always ready, 1 one-on/three-off, 2 never

    int         ar_wait;
    logic [1:0] tcnt;

    // Memory slave: rdata = addr*3, rvalid one cycle after the AR handshake
    assign bus.m_axil_arready = bus.m_axil_arvalid && (ar_wait >= ar_dly);
    assign bus.m_tready = (tr_mode == 0) || ((tr_mode == 1) && (tcnt == 2'd0));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_wait          <= 0;
            tcnt             <= 2'd0;
            bus.m_axil_rvalid <= 1'b0;
            bus.m_axil_rdata  <= '0;
            bus.m_axil_rresp  <= 2'b00;
        end else begin
            tcnt <= tcnt + 2'd1;
            if (bus.m_axil_arvalid && bus.m_axil_arready) begin
                ar_wait           <= 0;
                bus.m_axil_rvalid <= 1'b1;
                bus.m_axil_rdata  <= DW'(bus.m_axil_araddr) * DW'(3);
                bus.m_axil_rresp  <= (int'(bus.m_axil_araddr) == err_addr) ? 2'b10 : 2'b00;
            end else if (bus.m_axil_arvalid) begin
                ar_wait <= ar_wait + 1;
            end else begin
                ar_wait <= 0;
            end
            if (bus.m_axil_rvalid && bus.m_axil_rready) bus.m_axil_rvalid <= 1'b0;
        end
    end

    // Monitor: records handshakes and protocol-stability violations
    logic [AW-1:0] ar_q[$];
    logic [DW-1:0] td_q[$];
    logic          tl_q[$];
    int            done_cnt = 0;
    int            busy_cnt = 0;
    int            viol     = 0;
    logic          p_tv = 1'b0, p_tr = 1'b0, p_tl = 1'b0, p_av = 1'b0, p_ar = 1'b0;
    logic [DW-1:0] p_td = '0;
    logic [AW-1:0] p_aa = '0;

    always @(negedge clk) begin
        if (bus.m_axil_arvalid && bus.m_axil_arready) ar_q.push_back(bus.m_axil_araddr);
        if (bus.m_tvalid && bus.m_tready) begin
            td_q.push_back(bus.m_tdata);
            tl_q.push_back(bus.m_tlast);
        end
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (p_tv && !p_tr && bus.m_tvalid &&
            ((bus.m_tdata !== p_td) || (bus.m_tlast !== p_tl))) viol++;
        if (p_av && !p_ar && bus.m_axil_arvalid && (bus.m_axil_araddr !== p_aa)) viol++;
        if (bus.m_axil_arvalid && bus.m_tvalid) viol++;
        p_tv = bus.m_tvalid;
        p_tr = bus.m_tready;
        p_td = bus.m_tdata;
        p_tl = bus.m_tlast;
        p_av = bus.m_axil_arvalid;
        p_ar = bus.m_axil_arready;
        p_aa = bus.m_axil_araddr;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] stride;
        logic [LW-1:0] len;
        int            ar_dly;
        int            err_addr;
        int            tr_mode;
        logic          exp_err;
        int            exp_cycles;  // start edge .. done visible; -1 = not checked
    } vec_t;

    vec_t vecs[8];

    task automatic wait_done(input int d0, input string name);
        int n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({name, " done seen"}, 64'(done_cnt != d0), 64'd1);
    endtask

    // Applies one table row and checks beats, addresses, done, err and timing
    task automatic run_vec(input vec_t v, input string tag);
        int            a0, b0, d0, bs0, v0, cyc;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        ar_dly   = v.ar_dly;
        err_addr = v.err_addr;
        tr_mode  = v.tr_mode;
        a0  = ar_q.size();
        b0  = td_q.size();
        d0  = done_cnt;
        bs0 = busy_cnt;
        v0  = viol;
        @(negedge clk);
        base   = v.base;
        stride = v.stride;
        len    = v.len;
        start  = 1'b1;
        cyc    = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1 start = 1'b0;
        end while (!done && cyc < 5000);
        repeat (3) @(negedge clk);
        #1;
        if (v.exp_cycles >= 0) chk({tag, " cycles"}, 64'(cyc), 64'(v.exp_cycles));
        chk({tag, " beats"}, 64'(td_q.size() - b0), 64'(v.len));
        chk({tag, " ar count"}, 64'(ar_q.size() - a0), 64'(v.len));
        for (int k = 0; k < int'(v.len); k++) begin
            ea = v.base + AW'(k) * v.stride;
            ed = DW'(ea) * DW'(3);
            if (b0 + k < td_q.size()) begin
                chk($sformatf("%s beat%0d data", tag, k), 64'(td_q[b0 + k]), 64'(ed));
                chk($sformatf("%s beat%0d last", tag, k), 64'(tl_q[b0 + k]),
                    64'(k == int'(v.len) - 1));
            end
            if (a0 + k < ar_q.size())
                chk($sformatf("%s addr%0d", tag, k), 64'(ar_q[a0 + k]), 64'(ea));
        end
        chk({tag, " done pulses"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, " err"}, 64'(err), 64'(v.exp_err));
        chk({tag, " busy seen"}, 64'(busy_cnt != bs0), 64'(v.len != '0));
        chk({tag, " stability"}, 64'(viol - v0), 64'd0);
    endtask

    initial begin
        int a0, b0, d0, n;

        //         base  stride len  ar_dly err_addr mode err cycles
        vecs[0] = '{10'd0,    10'd8, 11'd32, 1, -1, 0, 1'b0, 129};
        vecs[1] = '{10'd256,  10'd4, 11'd4,  2, -1, 1, 1'b0, -1};
        vecs[2] = '{10'd1020, 10'd2, 11'd3,  0, -1, 0, 1'b0, 10};
        vecs[3] = '{10'd5,    10'd1, 11'd0,  0, -1, 0, 1'b0, 1};
        vecs[4] = '{10'd7,    10'd0, 11'd3,  0, -1, 0, 1'b0, 10};
        vecs[5] = '{10'd16,   10'd1, 11'd3,  0, 17, 0, 1'b1, 10};
        vecs[6] = '{10'd3,    10'd1, 11'd1,  0, -1, 0, 1'b0, 4};
        vecs[7] = '{10'd200,  10'd2, 11'd2,  0, -1, 0, 1'b0, 7};

        rst_n  = 1'b0;
        start  = 1'b0;
        base   = '0;
        stride = '0;
        len    = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset err", 64'(err), 64'd0);
        chk("reset arvalid", 64'(bus.m_axil_arvalid), 64'd0);
        chk("reset araddr", 64'(bus.m_axil_araddr), 64'd0);
        chk("reset rready", 64'(bus.m_axil_rready), 64'd0);
        chk("reset tvalid", 64'(bus.m_tvalid), 64'd0);
        chk("reset tdata", 64'(bus.m_tdata), 64'd0);
        chk("reset tlast", 64'(bus.m_tlast), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("row%0d", i));

        // Error timing: beat 2 (addr 41) errors; err rises after its R edge
        ar_dly   = 0;
        err_addr = 41;
        tr_mode  = 0;
        d0 = done_cnt;
        @(negedge clk);
        base = 10'd40; stride = 10'd1; len = 11'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("errseq busy after start", 64'(busy), 64'd1);
        chk("errseq err cleared", 64'(err), 64'd0);
        repeat (4) @(posedge clk);
        #1 chk("errseq err before R2", 64'(err), 64'd0);
        @(posedge clk);
        #1 chk("errseq err after R2", 64'(err), 64'd1);
        wait_done(d0, "errseq");
        repeat (2) @(negedge clk);
        #1 chk("errseq err sticky", 64'(err), 64'd1);
        err_addr = -1;
        d0 = done_cnt;
        @(negedge clk);
        base = 10'd0; stride = 10'd1; len = 11'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("errseq err cleared by start", 64'(err), 64'd0);
        wait_done(d0, "errseq2");

        // Start while busy must not disturb the running sweep
        a0 = ar_q.size();
        b0 = td_q.size();
        d0 = done_cnt;
        @(negedge clk);
        base = 10'd64; stride = 10'd4; len = 11'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        base = 10'd512; stride = 10'd1; len = 11'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0, "busystart");
        repeat (3) @(negedge clk);
        #1;
        chk("busystart beats", 64'(td_q.size() - b0), 64'd4);
        chk("busystart done pulses", 64'(done_cnt - d0), 64'd1);
        for (int k = 0; k < 4; k++)
            if (a0 + k < ar_q.size())
                chk($sformatf("busystart addr%0d", k), 64'(ar_q[a0 + k]), 64'(64 + 4 * k));

        // Asynchronous reset while holding a beat in OUT
        tr_mode = 2;
        @(negedge clk);
        base = 10'd100; stride = 10'd1; len = 11'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!bus.m_tvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rstseq reached OUT", 64'(bus.m_tvalid), 64'd1);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("rstseq tvalid drop", 64'(bus.m_tvalid), 64'd0);
        chk("rstseq arvalid drop", 64'(bus.m_axil_arvalid), 64'd0);
        chk("rstseq rready drop", 64'(bus.m_axil_rready), 64'd0);
        chk("rstseq busy drop", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        tr_mode = 0;
        repeat (3) @(negedge clk);
        #1 chk("rstseq no done", 64'(done_cnt - d0), 64'd0);
        run_vec(vecs[7], "row7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axil_rd_streamer.md
Name: axil_rd_streamer

Overview:
- AXI-Lite read initiator that sweeps a programmable address range of the procedural capture block's AXI-Lite read port.
- Repacks the returned words as one AXI-Stream packet, with tlast on the final word.
- Replaces bench-driven address sweeps with a synthesizable readout path toward downstream stream logic or a DMA.
- One read outstanding at a time.

Parameters:
DW, 32, data width of the AXI-Lite read data and the stream data
G_ADDR_WIDTH, 10, AXI-Lite address width; matches the capture block's index width
G_LEN_WIDTH, G_ADDR_WIDTH+1, width of the word-count input

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  single-cycle start request; ignored while o_busy=1
i_base  in  G_ADDR_WIDTH  first read address, latched on accepted start
i_stride  in  G_ADDR_WIDTH  address increment per word, latched on accepted start
i_len  in  G_LEN_WIDTH  number of words, latched on accepted start
o_busy  out  1  high from the cycle after an accepted start until the cycle after the last stream handshake
o_done  out  1  one-cycle pulse when the sweep completes
o_err  out  1  sticky error: any rresp!=0 seen in the current sweep; cleared on accepted start
m_axil_arvalid  out  1  read address valid
m_axil_arready  in  1  read address ready
m_axil_araddr  out  G_ADDR_WIDTH  read address
m_axil_rvalid  in  1  read data valid
m_axil_rready  out  1  read data ready
m_axil_rdata  in  DW  read data
m_axil_rresp  in  2  read response
m_tvalid  out  1  stream valid
m_tready  in  1  stream ready
m_tdata  out  DW  stream data
m_tlast  out  1  last word of sweep

Behaviour:
- Reset (async, i_rst_n=0):
  - All outputs 0; m_axil_araddr=0, m_tdata=0.
  - FSM returns to IDLE, counters cleared.
  - Reset mid-sweep abandons the sweep with no o_done.
  - The external slave must be reset together with this block.
- FSM states: IDLE, AR, R, OUT.
- IDLE:
  - On i_start=1: latch base, stride, len; clear o_err; o_busy=1 next cycle.
  - If len=0: stay IDLE, pulse o_done the next cycle, o_busy stays 0.
  - Otherwise go to AR, with m_axil_arvalid=1 and araddr=base on the next cycle.
- AR:
  - arvalid held high and araddr held stable until arvalid&&arready.
  - On handshake: arvalid=0 next cycle, go to R.
- R:
  - rready=1.
  - On rvalid&&rready: capture rdata into the m_tdata register.
  - OR (rresp!=0) into o_err.
  - Set m_tlast when word index = len-1.
  - rready=0 next cycle; go to OUT with m_tvalid=1.
- OUT:
  - m_tvalid, m_tdata, m_tlast held stable until m_tready.
  - On handshake, not last: m_tvalid=0, advance address, go to AR (arvalid next cycle).
  - On handshake, last: m_tvalid=0, m_tlast=0, o_done pulse, o_busy=0 next cycle, go to IDLE.
- Address arithmetic:
  - addr_next = addr + stride, modulo 2^G_ADDR_WIDTH (silent wrap, no error).
  - stride=0 rereads the same address len times.
- Throughput: with always-ready slave and sink, one word per 3 cycles (AR, R, OUT).
- Ordering: exactly one AR outstanding; rvalid seen outside R is ignored (rready=0).
- i_start while busy is ignored, including any new base, stride and len values.
- o_err still forwards the data of an erroring beat; o_err persists after o_done until the next accepted start.

Test Plan:
- Basic sweep: base=0, stride=8, len=32; slave returns rdata=addr*3 with arready/rvalid 1 cycle after request; m_tready=1 -> 32 beats, data 0,24,…,744; tlast only on beat 32; one o_done; o_err=0; araddr sequence 0,8,…,248.
- Backpressure: len=4; m_tready toggles 1 cycle on/3 off; slave arready delayed 2 cycles -> araddr stable while waiting, m_tdata/m_tlast stable while m_tvalid&&!m_tready, no second arvalid before the previous stream beat completes, 4 beats in order.
- Wrap and zero-length: base=1020, stride=2, len=3 -> araddr 1020,1022,0. Separately len=0 -> no arvalid, o_done pulse 1 cycle after start, o_busy never high.
- Error response: len=3; second beat rresp=2 -> all 3 beats forwarded; o_err=1 from the cycle after beat 2's R handshake, stays 1 after o_done; next start clears it.
- Start while busy and mid-sweep reset:
  - i_start pulsed with base=512 during a sweep -> ignored, addresses unaffected.
  - i_rst_n=0 asynchronously during OUT -> m_tvalid, arvalid and rready drop immediately; no o_done.
  - New start after release -> sweep begins from the new base.
